// File: rtl/exu_wb_regfile.sv
// -----------------------------------------------------------------------------
// exu_wb_regfile
//
// GPR file fed by the EXU register-write interface through a one-entry
// writeback buffer. A request is accepted with a valid/ready handshake,
// held in the buffer, and committed to the array on the following edge
// unless wb_stall_i holds it. Two combinational read ports serve the
// decoder. Register x0 always reads as zero.
//
// Optional feature (compile-time macro): REGFILE_BYPASS_EN
//   When defined, reads that hit the register held in the buffer return the
//   buffered data before it has been committed (this also applies while
//   the buffer is stalled). When undefined, reads see array contents only.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   in_valid_i     EXU write request valid
//   in_ready_o     buffer can take a request this cycle
//   in_wen_i       request writes a register
//   in_waddr_i     destination register index
//   in_wdata_i     write data
//   wb_stall_i     holds the buffered entry, blocks its commit
//   raddr1_i/2_i   read indices
//   rdata1_o/2_o   read data (combinational)
//   commit_valid_o buffered entry commits at the next posedge
//   commit_wen_o   buffered entry's wen (0 while empty)
//   commit_addr_o  buffered entry's index (0 while empty)
// -----------------------------------------------------------------------------
module exu_wb_regfile #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  in_wen_i,
   input  logic [ADDR_WIDTH-1:0] in_waddr_i,
   input  logic [DATA_WIDTH-1:0] in_wdata_i,
   input  logic                  wb_stall_i,
   input  logic [ADDR_WIDTH-1:0] raddr1_i,
   input  logic [ADDR_WIDTH-1:0] raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o,
   output logic                  commit_valid_o,
   output logic                  commit_wen_o,
   output logic [ADDR_WIDTH-1:0] commit_addr_o
);

   // NUM_REGS may equal 2^ADDR_WIDTH, so compare with one extra bit.
   localparam int                NUM_REGS_INT = NUM_REGS;
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS_INT[ADDR_WIDTH:0];

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state_q, state_d;
   logic                  buf_wen_q;
   logic [ADDR_WIDTH-1:0] buf_addr_q;
   logic [DATA_WIDTH-1:0] buf_data_q;

   logic                  commit;
   logic                  accept;
   logic                  gpr_we;

   logic [DATA_WIDTH-1:0] gpr_q [NUM_REGS];

   // Index refers to an implemented, writable register (not x0).
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && ({1'b0, a} < NUM_REGS_W);
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      commit     = 1'b0;
      in_ready_o = 1'b0;
      accept     = 1'b0;
      state_d    = state_q;

      commit     = (state_q == FULL) && !wb_stall_i;
      // A committing entry frees the slot in the same cycle: no bubble.
      in_ready_o = (state_q == EMPTY) || commit;
      accept     = in_valid_i && in_ready_o;

      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (commit && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // ------------------------------------------------------- buffer entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_wen_q  <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
      end else if (accept) begin
         buf_wen_q  <= in_wen_i;
         buf_addr_q <= in_waddr_i;
         buf_data_q <= in_wdata_i;
      end
   end

   assign commit_valid_o = commit;
   assign commit_wen_o   = (state_q == FULL) ? buf_wen_q  : 1'b0;
   assign commit_addr_o  = (state_q == FULL) ? buf_addr_q : '0;

   // Commits with wen=0, to x0 or to an unimplemented index retire silently.
   assign gpr_we = commit && buf_wen_q && addr_ok(buf_addr_q);

   // ---------------------------------------------------------- GPR array
   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            gpr_q[gi] <= '0;
         end else if (gpr_we && (buf_addr_q == ADDR_WIDTH'(gi))) begin
            gpr_q[gi] <= buf_data_q;
         end
      end
   end

   // --------------------------------------------------------- read ports
`ifdef REGFILE_BYPASS_EN
   logic byp_valid;
   assign byp_valid = (state_q == FULL) && buf_wen_q && addr_ok(buf_addr_q);
`endif

   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (addr_ok(raddr1_i)) rdata1_o = gpr_q[raddr1_i];
      if (addr_ok(raddr2_i)) rdata2_o = gpr_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
      if (byp_valid && (raddr1_i == buf_addr_q)) rdata1_o = buf_data_q;
      if (byp_valid && (raddr2_i == buf_addr_q)) rdata2_o = buf_data_q;
`endif
   end

endmodule
